// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter states, parity modes and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Data is zero-extended by the caller; the padding bits do not change the XOR.
  function automatic logic par_bit(input logic [8:0] data, input int mode);
    logic p;
    p = ^data;
    case (mode)
      PAR_EVEN: return p;
      PAR_ODD:  return ~p;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period timer: bit_done marks the final clock of each bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_done
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  assign bit_done = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || restart || bit_done) count <= '0;
    else                            count <= count + W'(1);
  end

endmodule

// File: rtl/uart_tx_stream.sv
// UART transmitter that pops words from a FIFO read port and serialises them
// with start, optional parity and stop bits.
module uart_tx_stream #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] src_data,
  input  logic                 src_rrdy,
  output logic                 src_ren,
  output logic                 txd,
  output logic                 busy
);

  import uart_pkg::*;

  localparam int IDX_W = $clog2(DATA_BITS + 1);

  tx_state_e            state, state_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [IDX_W-1:0]     bit_idx, bit_idx_n;
  logic                 stop_idx, stop_idx_n;
  logic                 par_q, par_n;
  logic                 txd_n, busy_n;
  logic                 bit_done, last_cycle;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .restart  (state == IDLE),
    .bit_done (bit_done)
  );

  assign last_cycle = (state == STOP) && bit_done && (stop_idx == 1'(STOP_BITS - 1));
  assign src_ren    = !rst && src_rrdy && ((state == IDLE) || last_cycle);

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    par_n      = par_q;
    if (src_ren) begin
      state_n    = START;
      shreg_n    = src_data;
      par_n      = par_bit(9'(src_data), PARITY);
      bit_idx_n  = '0;
      stop_idx_n = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        START: if (bit_done) state_n = DATA;
        DATA: if (bit_done) begin
          shreg_n = shreg >> 1;
          if (bit_idx == IDX_W'(DATA_BITS - 1))
            state_n = (PARITY != PAR_NONE) ? PAR : STOP;
          else
            bit_idx_n = bit_idx + IDX_W'(1);
        end
        PAR: if (bit_done) state_n = STOP;
        STOP: if (bit_done) begin
          if (last_cycle) state_n = IDLE;
          else            stop_idx_n = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end

    // Line level is derived from the next state so txd is a clean register.
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shreg_n[0];
      PAR:     txd_n = par_n;
      default: txd_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_q    <= 1'b0;
      txd      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_idx  <= bit_idx_n;
      stop_idx <= stop_idx_n;
      par_q    <= par_n;
      txd      <= txd_n;
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream: four configurations (no parity, even,
// odd, two stop bits) checked cycle by cycle against hand-built frames.
module tb_uart_tx_stream;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] src_data [4];
  logic       src_rrdy [4];
  logic       src_ren  [4];
  logic       txd      [4];
  logic       busy     [4];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int par_of [4] = '{0, 1, 2, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_stream #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .src_data(src_data[0]), .src_rrdy(src_rrdy[0]),
    .src_ren(src_ren[0]), .txd(txd[0]), .busy(busy[0]));
  uart_tx_stream #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .src_data(src_data[1]), .src_rrdy(src_rrdy[1]),
    .src_ren(src_ren[1]), .txd(txd[1]), .busy(busy[1]));
  uart_tx_stream #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .src_data(src_data[2]), .src_rrdy(src_rrdy[2]),
    .src_ren(src_ren[2]), .txd(txd[2]), .busy(busy[2]));
  uart_tx_stream #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut3 (
    .clk(clk), .rst(rst), .src_data(src_data[3]), .src_rrdy(src_rrdy[3]),
    .src_ren(src_ren[3]), .txd(txd[3]), .busy(busy[3]));

  typedef struct {
    int         k;
    logic [7:0] data;
    logic       par;
    int         flen;
  } vec_t;

  vec_t vecs [7];

  function automatic logic exp_txd(int k, logic [7:0] d, logic p, int c);
    int b;
    b = c / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (par_of[k] != 0 && b == 9) return p;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One isolated frame; the source empties right after the pop.
  task automatic run_frame(input vec_t v);
    src_data[v.k] = v.data;
    src_rrdy[v.k] = 1'b1;
    @(negedge clk);
    chk("pop", src_ren[v.k], 1'b1);
    chk("pre_txd", txd[v.k], 1'b1);
    chk("pre_busy", busy[v.k], 1'b0);
    tick();
    src_rrdy[v.k] = 1'b0;
    src_data[v.k] = ~v.data;
    for (int c = 0; c <= v.flen; c++) begin
      @(negedge clk);
      if (c < v.flen) begin
        chk("txd", txd[v.k], exp_txd(v.k, v.data, v.par, c));
        chk("busy", busy[v.k], 1'b1);
        chk("ren_mid", src_ren[v.k], 1'b0);
      end else begin
        chk("end_txd", txd[v.k], 1'b1);
        chk("end_busy", busy[v.k], 1'b0);
      end
      tick();
    end
  endtask

  // Two words queued; the second pop must land on the frame's last cycle.
  task automatic back_to_back(input int k, input logic [7:0] d0, input logic [7:0] d1,
                              input int flen);
    src_data[k] = d0;
    src_rrdy[k] = 1'b1;
    @(negedge clk);
    chk("b2b_pop0", src_ren[k], 1'b1);
    tick();
    src_data[k] = d1;
    for (int c = 0; c <= 2 * flen; c++) begin
      @(negedge clk);
      if (c < 2 * flen) begin
        chk("b2b_txd", txd[k], exp_txd(k, (c < flen) ? d0 : d1, 1'b0, c % flen));
        chk("b2b_busy", busy[k], 1'b1);
        chk("b2b_ren", src_ren[k], (c == flen - 1) ? 1'b1 : 1'b0);
      end else begin
        chk("b2b_end_txd", txd[k], 1'b1);
        chk("b2b_end_busy", busy[k], 1'b0);
        chk("b2b_end_ren", src_ren[k], 1'b0);
      end
      tick();
      if (c == flen - 1) src_rrdy[k] = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{k: 0, data: 8'hA5, par: 1'b0, flen: 40};
    vecs[1] = '{k: 1, data: 8'h07, par: 1'b1, flen: 44};
    vecs[2] = '{k: 2, data: 8'h07, par: 1'b0, flen: 44};
    vecs[3] = '{k: 3, data: 8'h3C, par: 1'b0, flen: 44};
    vecs[4] = '{k: 1, data: 8'h00, par: 1'b0, flen: 44};
    vecs[5] = '{k: 2, data: 8'h00, par: 1'b1, flen: 44};
    vecs[6] = '{k: 0, data: 8'hFF, par: 1'b0, flen: 40};

    for (int i = 0; i < 4; i++) begin
      src_data[i] = 8'h00;
      src_rrdy[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) src_rrdy[i] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_txd", txd[i], 1'b1);
      chk("rst_busy", busy[i], 1'b0);
      chk("rst_ren", src_ren[i], 1'b0);
    end
    tick();
    for (int i = 0; i < 4; i++) src_rrdy[i] = 1'b0;
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    back_to_back(0, 8'h00, 8'hFF, 40);
    back_to_back(3, 8'h3C, 8'h5A, 44);

    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("idle_ren", src_ren[0], 1'b0);
      chk("idle_txd", txd[0], 1'b1);
      chk("idle_busy", busy[0], 1'b0);
      tick();
    end

    // Reset in the middle of a frame while more data is waiting.
    src_data[0] = 8'hA5;
    src_rrdy[0] = 1'b1;
    @(negedge clk);
    chk("mr_pop", src_ren[0], 1'b1);
    tick();
    src_data[0] = 8'h3C;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      chk("mr_txd", txd[0], exp_txd(0, 8'hA5, 1'b0, c));
      chk("mr_busy", busy[0], 1'b1);
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mr_ren_rst", src_ren[0], 1'b0);
    tick();
    @(negedge clk);
    chk("mr_txd_after", txd[0], 1'b1);
    chk("mr_busy_after", busy[0], 1'b0);
    chk("mr_ren_rst_idle", src_ren[0], 1'b0);
    tick();
    rst = 1'b0;
    run_frame('{k: 0, data: 8'h3C, par: 1'b0, flen: 40});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
Serial UART transmitter that drains a synchronous FIFO read port (rdata / rrdy / ren style handshake) and shifts each word out on a single line. It is the consumer end of the FIFO stream: it pops one word per frame and serialises it with start, optional parity and stop bits. It sits between a synch FIFO and the chip's TX pad.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 2
DATA_BITS, 8, data bits per frame; range 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits; 1 or 2

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
src_data  input  DATA_BITS  word at head of source FIFO; valid when src_rrdy=1
src_rrdy  input  1  source has a word available
src_ren  output  1  pop strobe; combinational, one cycle per consumed word
txd  output  1  serial line, registered, idle high
busy  output  1  registered; 1 while a frame is on the line

Behaviour:
- Reset: rst is synchronous, active-high. Next edge gives state=IDLE, txd=1, busy=0, counters 0. src_ren=0 whenever rst=1, regardless of state.
- src_ren = !rst && src_rrdy && (state==IDLE || last_cycle_of_frame). src_data is sampled into the shift register on the same edge that src_ren is high.
- States: IDLE -> START -> DATA -> [PARITY if PARITY!=0] -> STOP -> IDLE or START.
- Each bit lasts exactly CLKS_PER_BIT cycles. Bit timer counts 0..CLKS_PER_BIT-1; bit_done = (count==CLKS_PER_BIT-1).
- START: txd=0.
- DATA: LSB first; bit index 0..DATA_BITS-1.
- PARITY: txd = XOR of data bits (even) or its inverse (odd).
- STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Latency: txd goes low on the cycle after the src_ren cycle.
- Frame length: F = CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
- last_cycle_of_frame is the final cycle of the last stop bit.
- Back-to-back: if src_rrdy=1 in last_cycle_of_frame, the next START begins the following cycle with no idle gap. Otherwise go to IDLE with txd=1.
- busy=1 from the first START cycle through the last STOP cycle inclusive. busy=0 in IDLE.
- src_rrdy dropping mid-frame has no effect on the current frame. src_data is ignored except in the sampling cycle.
- Reset mid-frame: the frame is aborted and the word is lost (already popped). txd=1 and busy=0 from the cycle after the rst edge.
- Widths: the bit timer uses $clog2(CLKS_PER_BIT) bits. The bit index uses $clog2(DATA_BITS+1) bits. No counter wraps mid-state.

Decomposition:
- Package uart_pkg:
  - state enum tx_state_e {IDLE, START, DATA, PAR, STOP}
  - parity constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2
  - function par_bit(data, mode)
- Sub-module uart_bit_timer (CLKS_PER_BIT): inputs clk, rst, restart; output bit_done. It is shared with the future RX.

Test Plan:
- CLKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1; FIFO holds 0xA5 -> one src_ren pulse. txd low 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then high 4 cycles; 40 cycles total with busy=1, then idle.
- Same config, FIFO holds 0x00 then 0xFF -> src_ren pulses exactly 40 cycles apart. txd shows 36 lows, 4 highs, 4 lows, then 36 highs, with no idle gap; busy high 80 cycles.
- PARITY=1, data 0x07 -> parity bit 1. PARITY=2, data 0x07 -> parity bit 0. Frame is 44 cycles.
- STOP_BITS=2, data 0x3C -> stop level high for 8 cycles. Next src_ren coincides with the 8th stop cycle.
- src_rrdy=0 for 100 cycles -> src_ren=0, txd=1, busy=0 throughout.
- rst asserted at cycle 15 of a 0xA5 frame while src_rrdy=1 -> src_ren=0 during rst, txd=1 and busy=0 the next cycle. After release, the next word starts a fresh frame.
